// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alarm_pkg
// Brief   : Shared field offsets and FSM state encoding for the alarm trigger.
// Revision: 1.0
// ============================================================================
package alarm_pkg;

    localparam int ON_BIT  = 15;
    localparam int DAY_HI  = 14;
    localparam int DAY_LO  = 12;
    localparam int HOUR_HI = 11;
    localparam int HOUR_LO = 7;
    localparam int MT_HI   = 6;
    localparam int MT_LO   = 4;
    localparam int MO_HI   = 3;
    localparam int MO_LO   = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

endpackage
`default_nettype wire

// File: rtl/rise_detect_module.sv
`default_nettype none
// ============================================================================
// Module  : rise_detect_module
// Brief   : Registered-history rising-edge detector with a selectable reset value.
// Revision: 1.0
// ============================================================================
module rise_detect_module #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_d;

    // A reset value of 1 masks an input that is already high when reset releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_d <= RESET_VAL;
        end else begin
            din_d <= din;
        end
    end

    assign pulse = din & ~din_d;

endmodule
`default_nettype wire

// File: rtl/alarm_trigger_module.sv
`default_nettype none
// ============================================================================
// Module  : alarm_trigger_module
// Brief   : Alarm match detection, ringing, snooze and auto-stop control.
// Revision: 1.0
// ============================================================================
module alarm_trigger_module #(
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_SEC     = 60,
    parameter int DAY_MATCH_EN = 1
) (
    input  logic        CLK,
    input  logic        CLEAR_N,
    input  logic [15:0] STO,
    input  logic [14:0] CTI,
    input  logic        TICK_SEC,
    input  logic        TICK_MIN,
    input  logic        SNOOZE,
    input  logic        STOP,
    output logic        BUZZ,
    output logic        SNOOZING,
    output logic [2:0]  SNOOZE_CNT,
    output logic        MISSED
);

    import alarm_pkg::*;

    localparam logic [3:0] SNZ_LOAD  = 4'(SNOOZE_MIN);
    localparam logic [2:0] SNZ_LIMIT = 3'(MAX_SNOOZE);
    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    logic match;
    logic day_ok;
    logic fire;
    logic snz_p;
    logic stop_p;
    logic armed;

    alarm_state_t state;
    alarm_state_t state_nxt;
    logic [7:0]   ring_cnt;
    logic [7:0]   ring_cnt_nxt;
    logic [3:0]   snz_timer;
    logic [3:0]   snz_timer_nxt;
    logic [2:0]   snz_cnt_nxt;
    logic         missed_nxt;

    assign armed  = STO[ON_BIT];
    assign day_ok = (DAY_MATCH_EN == 0) || (CTI[DAY_HI:DAY_LO] == STO[DAY_HI:DAY_LO]);
    assign match  = armed && (CTI[HOUR_HI:MO_LO] == STO[HOUR_HI:MO_LO]) && day_ok;

    rise_detect_module #(.RESET_VAL(1'b1)) u_match_rise (
        .clk   (CLK),
        .rst_n (CLEAR_N),
        .din   (match),
        .pulse (fire)
    );

    rise_detect_module #(.RESET_VAL(1'b1)) u_snooze_rise (
        .clk   (CLK),
        .rst_n (CLEAR_N),
        .din   (SNOOZE),
        .pulse (snz_p)
    );

    rise_detect_module #(.RESET_VAL(1'b1)) u_stop_rise (
        .clk   (CLK),
        .rst_n (CLEAR_N),
        .din   (STOP),
        .pulse (stop_p)
    );

    // Outputs are registered from the next-state decode so they track state exactly
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state      <= IDLE;
            ring_cnt   <= 8'd0;
            snz_timer  <= 4'd0;
            SNOOZE_CNT <= 3'd0;
            BUZZ       <= 1'b0;
            SNOOZING   <= 1'b0;
            MISSED     <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring_cnt   <= ring_cnt_nxt;
            snz_timer  <= snz_timer_nxt;
            SNOOZE_CNT <= snz_cnt_nxt;
            BUZZ       <= (state_nxt == RINGING);
            SNOOZING   <= (state_nxt == alarm_pkg::SNOOZE);
            MISSED     <= missed_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ring_cnt_nxt  = ring_cnt;
        snz_timer_nxt = snz_timer;
        snz_cnt_nxt   = SNOOZE_CNT;
        missed_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (fire) begin
                    state_nxt    = RINGING;
                    ring_cnt_nxt = 8'd0;
                    snz_cnt_nxt  = 3'd0;
                end
            end
            RINGING: begin
                if (!armed || stop_p) begin
                    state_nxt = IDLE;
                end else if (snz_p && (SNOOZE_CNT < SNZ_LIMIT)) begin
                    state_nxt     = alarm_pkg::SNOOZE;
                    snz_timer_nxt = SNZ_LOAD;
                    snz_cnt_nxt   = SNOOZE_CNT + 3'd1;
                end else if (TICK_SEC) begin
                    if (ring_cnt == RING_LAST) begin
                        state_nxt  = IDLE;
                        missed_nxt = 1'b1;
                    end else begin
                        ring_cnt_nxt = ring_cnt + 8'd1;
                    end
                end
            end
            alarm_pkg::SNOOZE: begin
                if (!armed || stop_p) begin
                    state_nxt = IDLE;
                end else if (TICK_MIN) begin
                    if (snz_timer == 4'd1) begin
                        state_nxt    = RINGING;
                        ring_cnt_nxt = 8'd0;
                    end else begin
                        snz_timer_nxt = snz_timer - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_trigger_module.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_trigger_module
// Brief   : Directed and randomized checks of alarm_trigger_module against a model.
// Revision: 1.0
// ============================================================================
module tb_alarm_trigger_module;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sto;
    logic [14:0] cti;
    logic        tick_sec;
    logic        tick_min;
    logic        snz;
    logic        stp;
    logic [1:0]  buzz;
    logic [1:0]  snoozing;
    logic [1:0]  missed;
    logic [5:0]  scnt;

    int checks = 0;
    int passes = 0;

    // Reference model state; index 0 = day-checking instance, 1 = every-day instance
    int m_mode [2];
    int m_secs [2];
    int m_left [2];
    int m_cnt  [2];
    bit m_pm   [2];
    bit m_psnz [2];
    bit m_pstop[2];
    bit m_missed[2];

    always #5 clk = ~clk;

    alarm_trigger_module u_dut_day (
        .CLK        (clk),
        .CLEAR_N    (rst_n),
        .STO        (sto),
        .CTI        (cti),
        .TICK_SEC   (tick_sec),
        .TICK_MIN   (tick_min),
        .SNOOZE     (snz),
        .STOP       (stp),
        .BUZZ       (buzz[0]),
        .SNOOZING   (snoozing[0]),
        .SNOOZE_CNT (scnt[2:0]),
        .MISSED     (missed[0])
    );

    alarm_trigger_module #(.DAY_MATCH_EN(0)) u_dut_any (
        .CLK        (clk),
        .CLEAR_N    (rst_n),
        .STO        (sto),
        .CTI        (cti),
        .TICK_SEC   (tick_sec),
        .TICK_MIN   (tick_min),
        .SNOOZE     (snz),
        .STOP       (stp),
        .BUZZ       (buzz[1]),
        .SNOOZING   (snoozing[1]),
        .SNOOZE_CNT (scnt[5:3]),
        .MISSED     (missed[1])
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]   = M_IDLE;
            m_secs[k]   = 0;
            m_left[k]   = 0;
            m_cnt[k]    = 0;
            m_pm[k]     = 1'b1;
            m_psnz[k]   = 1'b1;
            m_pstop[k]  = 1'b1;
            m_missed[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit on, m, fire, sp, tp;
        on   = sto[15];
        m    = on && (cti[11:0] == sto[11:0]) && (k == 1 || cti[14:12] == sto[14:12]);
        fire = m && !m_pm[k];
        sp   = snz && !m_psnz[k];
        tp   = stp && !m_pstop[k];
        m_pm[k]     = m;
        m_psnz[k]   = snz;
        m_pstop[k]  = stp;
        m_missed[k] = 1'b0;
        if (m_mode[k] == M_IDLE) begin
            if (fire) begin
                m_mode[k] = M_RING;
                m_secs[k] = 0;
                m_cnt[k]  = 0;
            end
        end else if (m_mode[k] == M_RING) begin
            if (!on || tp) begin
                m_mode[k] = M_IDLE;
            end else if (sp && m_cnt[k] < 3) begin
                m_mode[k] = M_SNZ;
                m_left[k] = 5;
                m_cnt[k]  = m_cnt[k] + 1;
            end else if (tick_sec) begin
                m_secs[k] = m_secs[k] + 1;
                if (m_secs[k] >= 60) begin
                    m_mode[k]   = M_IDLE;
                    m_missed[k] = 1'b1;
                end
            end
        end else begin
            if (!on || tp) begin
                m_mode[k] = M_IDLE;
            end else if (tick_min) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_mode[k] = M_RING;
                    m_secs[k] = 0;
                end
            end
        end
    endtask

    task automatic clk_step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (buzz !== 2'b00) $display("FAIL reset_buzz: got %b expected 00", buzz); else passes++;
        checks++; if (snoozing !== 2'b00) $display("FAIL reset_snoozing: got %b expected 00", snoozing); else passes++;
        checks++; if (scnt !== 6'd0) $display("FAIL reset_cnt: got %0d expected 0", scnt); else passes++;
        checks++; if (missed !== 2'b00) $display("FAIL reset_missed: got %b expected 00", missed); else passes++;
    endtask

    task automatic test_trigger();
        sto = {1'b1, 3'd2, 5'd7, 3'd3, 4'd0};
        cti = {3'd2, 5'd7, 3'd2, 4'd9};
        clk_step();
        checks++; if (buzz[0] !== 1'b0) $display("FAIL trig_pre: got %b expected 0", buzz[0]); else passes++;
        cti = {3'd2, 5'd7, 3'd3, 4'd0};
        tick_min = 1'b1;
        clk_step();
        tick_min = 1'b0;
        checks++; if (buzz !== 2'b11) $display("FAIL trig_buzz: got %b expected 11", buzz); else passes++;
        checks++; if (scnt[2:0] !== 3'd0) $display("FAIL trig_cnt: got %0d expected 0", scnt[2:0]); else passes++;
    endtask

    task automatic test_day();
        stp = 1'b1; clk_step(); stp = 1'b0; clk_step();
        checks++; if (buzz !== 2'b00) $display("FAIL day_stop: got %b expected 00", buzz); else passes++;
        cti = {3'd3, 5'd7, 3'd2, 4'd9}; clk_step();
        cti = {3'd3, 5'd7, 3'd3, 4'd0}; clk_step();
        checks++; if (buzz[0] !== 1'b0) $display("FAIL day_mismatch: got %b expected 0", buzz[0]); else passes++;
        checks++; if (buzz[1] !== 1'b1) $display("FAIL day_any: got %b expected 1", buzz[1]); else passes++;
    endtask

    task automatic test_snooze();
        stp = 1'b1; clk_step(); stp = 1'b0; clk_step();
        cti = {3'd2, 5'd7, 3'd2, 4'd9}; clk_step();
        cti = {3'd2, 5'd7, 3'd3, 4'd0}; clk_step();
        checks++; if (buzz[0] !== 1'b1) $display("FAIL snz_fire: got %b expected 1", buzz[0]); else passes++;
        for (int s = 1; s <= 3; s++) begin
            snz = 1'b1; clk_step(); snz = 1'b0;
            checks++; if ({snoozing[0], buzz[0], scnt[2:0]} !== {1'b1, 1'b0, 3'(s)})
                $display("FAIL snz_enter%0d: got %b expected %b", s, {snoozing[0], buzz[0], scnt[2:0]}, {1'b1, 1'b0, 3'(s)});
            else passes++;
            for (int t = 1; t <= 5; t++) begin
                tick_min = 1'b1; clk_step(); tick_min = 1'b0;
                checks++; if (buzz[0] !== (t == 5)) $display("FAIL snz_tick%0d_%0d: got %b expected %b", s, t, buzz[0], (t == 5)); else passes++;
                clk_step();
            end
        end
        snz = 1'b1; clk_step(); snz = 1'b0;
        checks++; if ({buzz[0], snoozing[0], scnt[2:0]} !== {1'b1, 1'b0, 3'd3})
            $display("FAIL snz_limit: got %b expected %b", {buzz[0], snoozing[0], scnt[2:0]}, {1'b1, 1'b0, 3'd3});
        else passes++;
    endtask

    task automatic test_timeout();
        stp = 1'b1; clk_step(); stp = 1'b0; clk_step();
        cti = {3'd2, 5'd7, 3'd3, 4'd1}; clk_step();
        sto = {1'b1, 3'd2, 5'd7, 3'd3, 4'd1}; clk_step();
        checks++; if (buzz[0] !== 1'b1) $display("FAIL to_fire: got %b expected 1", buzz[0]); else passes++;
        for (int i = 1; i <= 60; i++) begin
            tick_sec = 1'b1; clk_step(); tick_sec = 1'b0;
            checks++; if ({buzz[0], missed[0]} !== {(i < 60), (i == 60)})
                $display("FAIL to_tick%0d: got %b expected %b", i, {buzz[0], missed[0]}, {(i < 60), (i == 60)});
            else passes++;
            clk_step();
        end
        checks++; if (missed[0] !== 1'b0) $display("FAIL to_missed_len: got %b expected 0", missed[0]); else passes++;
    endtask

    task automatic test_stop_snooze();
        cti = {3'd2, 5'd7, 3'd3, 4'd2}; clk_step();
        sto = {1'b1, 3'd2, 5'd7, 3'd3, 4'd2}; clk_step();
        snz = 1'b1; clk_step(); snz = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick_min = 1'b1; clk_step(); tick_min = 1'b0; clk_step();
        end
        checks++; if ({buzz[0], scnt[2:0]} !== {1'b1, 3'd1}) $display("FAIL ss_ring: got %b expected %b", {buzz[0], scnt[2:0]}, {1'b1, 3'd1}); else passes++;
        snz = 1'b1; stp = 1'b1; clk_step(); snz = 1'b0; stp = 1'b0;
        checks++; if ({buzz[0], snoozing[0], scnt[2:0]} !== {1'b0, 1'b0, 3'd1})
            $display("FAIL ss_both: got %b expected %b", {buzz[0], snoozing[0], scnt[2:0]}, {1'b0, 1'b0, 3'd1});
        else passes++;
        cti = {3'd2, 5'd7, 3'd3, 4'd3}; clk_step();
        sto = {1'b1, 3'd2, 5'd7, 3'd3, 4'd3}; clk_step();
        snz = 1'b1; clk_step(); snz = 1'b0;
        checks++; if (snoozing[0] !== 1'b1) $display("FAIL ss_snz: got %b expected 1", snoozing[0]); else passes++;
        sto[15] = 1'b0; clk_step();
        checks++; if ({buzz[0], snoozing[0], scnt[2:0]} !== {1'b0, 1'b0, 3'd1})
            $display("FAIL ss_off: got %b expected %b", {buzz[0], snoozing[0], scnt[2:0]}, {1'b0, 1'b0, 3'd1});
        else passes++;
    endtask

    task automatic test_reset_mid();
        sto[15] = 1'b1; clk_step();
        checks++; if (buzz[0] !== 1'b1) $display("FAIL rm_fire: got %b expected 1", buzz[0]); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({buzz, scnt} !== 8'd0) $display("FAIL rm_async: got %b expected 0", {buzz, scnt}); else passes++;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++; if (buzz !== 2'b00) $display("FAIL rm_norefire%0d: got %b expected 00", i, buzz); else passes++;
        end
        cti = {3'd2, 5'd7, 3'd3, 4'd4}; clk_step();
        cti = {3'd2, 5'd7, 3'd3, 4'd3}; clk_step();
        checks++; if (buzz !== 2'b11) $display("FAIL rm_refire: got %b expected 11", buzz); else passes++;
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        do_reset();
        sto = {1'b1, 3'd2, 5'd7, 3'd3, 4'd0};
        for (int c = 0; c < 3000; c++) begin
            tick_sec = ($urandom_range(0, 1) == 0);
            tick_min = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) snz = ~snz;
            if ($urandom_range(0, 149) == 0) stp = ~stp;
            if ($urandom_range(0, 299) == 0) sto[15] = ~sto[15];
            if ($urandom_range(0, 9) == 0)
                cti = {3'($urandom_range(2, 3)), 5'd7, 3'd3, 4'($urandom_range(0, 2))};
            if ($urandom_range(0, 199) == 0)
                sto[14:0] = {3'($urandom_range(2, 3)), 5'd7, 3'd3, 4'($urandom_range(0, 2))};
            clk_step();
            for (int k = 0; k < 2; k++) begin
                got = {buzz[k], snoozing[k], (k == 0) ? scnt[2:0] : scnt[5:3], missed[k]};
                exp = {(m_mode[k] == M_RING), (m_mode[k] == M_SNZ), 3'(m_cnt[k]), m_missed[k]};
                checks++;
                if (got !== exp) $display("FAIL random[%0d] cyc %0d: got %b expected %b", k, c, got, exp);
                else passes++;
            end
        end
        tick_sec = 1'b0;
        tick_min = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        sto      = 16'd0;
        cti      = 15'd0;
        tick_sec = 1'b0;
        tick_min = 1'b0;
        snz      = 1'b0;
        stp      = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_trigger();
        test_day();
        test_snooze();
        test_timeout();
        test_stop_snooze();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
